// File: rtl/dot_product_seq.sv
// -----------------------------------------------------------------------------
// dot_product_seq
//   Sequencer for an external mac_unit. A start command loads a vector length.
//   The block then accepts operand pairs on a valid/ready stream and steers them
//   into mac_unit so that it accumulates an unsigned dot product. The finished
//   accumulator is presented on a valid/ready result port.
//
//   Optional feature macro: SAT_OVF_EN
//     defined   : overflow is tracked on a shadow sum; the result saturates to
//                 all-ones and o_res_ovf is raised.
//     undefined : the sum wraps modulo 2^ACC_W and o_res_ovf stays 0.
//
// Ports
//   i_clk          clock, rising edge
//   i_reset        asynchronous, active-low reset
//   i_start        command strobe, sampled only while idle
//   i_len          number of operand pairs, sampled with i_start
//   o_busy         high whenever the sequencer is not idle
//   i_op_valid     operand pair valid
//   o_op_ready     operand pair accepted this cycle (only while running)
//   i_op_a/i_op_b  activation / weight operand
//   o_mac_a/o_mac_b  operands to mac_unit (zero on cycles without a beat)
//   o_mac_acc_in   accumulator input to mac_unit
//   i_mac_acc_out  registered accumulator output from mac_unit
//   o_res_valid    result valid
//   i_res_ready    result consumer ready
//   o_res_data     dot-product result
//   o_res_ovf      result overflowed ACC_W
// -----------------------------------------------------------------------------
module dot_product_seq #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ACC_W  = 16,
    parameter int unsigned LEN_W  = 8
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [LEN_W-1:0]  i_len,
    output logic              o_busy,
    input  logic              i_op_valid,
    output logic              o_op_ready,
    input  logic [DATA_W-1:0] i_op_a,
    input  logic [DATA_W-1:0] i_op_b,
    output logic [DATA_W-1:0] o_mac_a,
    output logic [DATA_W-1:0] o_mac_b,
    output logic [ACC_W-1:0]  o_mac_acc_in,
    input  logic [ACC_W-1:0]  i_mac_acc_out,
    output logic              o_res_valid,
    input  logic              i_res_ready,
    output logic [ACC_W-1:0]  o_res_data,
    output logic              o_res_ovf
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    logic [1:0]       r_state;
    logic [LEN_W-1:0] r_cnt;
    logic             r_first;
    logic [ACC_W-1:0] r_res_data;
    logic             r_res_ovf;

    logic             w_beat;
    logic             w_ovf;
    logic [ACC_W-1:0] w_acc_in;

    always_comb begin
        o_op_ready = (r_state == S_RUN);
        w_beat     = i_op_valid && (r_state == S_RUN);
        // Gap cycles feed zeros so the accumulator simply holds its value.
        o_mac_a    = w_beat ? i_op_a : '0;
        o_mac_b    = w_beat ? i_op_b : '0;
    end

`ifdef SAT_OVF_EN
    // Shadow sum is wide enough that neither the product nor the carry is lost.
    localparam int unsigned SHW = ((2 * DATA_W > ACC_W) ? 2 * DATA_W : ACC_W) + 1;

    logic           r_ovf;
    logic [SHW-1:0] w_shadow;
    logic           w_shadow_ovf;

    always_comb begin
        w_shadow     = SHW'(w_acc_in) + SHW'(i_op_a) * SHW'(i_op_b);
        w_shadow_ovf = |w_shadow[SHW-1:ACC_W];
        w_ovf        = r_ovf;
        // Once overflowed, keep mac_unit pinned at the top of its range.
        if (r_first) begin
            w_acc_in = '0;
        end else if (r_ovf) begin
            w_acc_in = '1;
        end else begin
            w_acc_in = i_mac_acc_out;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_ovf <= 1'b0;
        end else if (r_state == S_IDLE && i_start) begin
            r_ovf <= 1'b0;
        end else if (w_beat && w_shadow_ovf) begin
            r_ovf <= 1'b1;
        end
    end
`else
    always_comb begin
        w_ovf    = 1'b0;
        w_acc_in = r_first ? '0 : i_mac_acc_out;
    end
`endif

    assign o_mac_acc_in = w_acc_in;
    assign o_busy       = (r_state != S_IDLE);
    assign o_res_valid  = (r_state == S_HOLD);
    assign o_res_data   = r_res_data;
    assign o_res_ovf    = r_res_ovf;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_first    <= 1'b1;
            r_res_data <= '0;
            r_res_ovf  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_cnt   <= i_len;
                        r_first <= 1'b1;
                        if (i_len == '0) begin
                            r_state    <= S_HOLD;
                            r_res_data <= '0;
                            r_res_ovf  <= 1'b0;
                        end else begin
                            r_state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (w_beat) begin
                        r_cnt   <= r_cnt - LEN_W'(1);
                        r_first <= 1'b0;
                        if (r_cnt == LEN_W'(1)) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                // mac_unit output now includes the final beat.
                S_DRAIN: begin
                    r_res_data <= w_ovf ? '1 : i_mac_acc_out;
                    r_res_ovf  <= w_ovf;
                    r_state    <= S_HOLD;
                end
                S_HOLD: begin
                    if (i_res_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dot_product_seq.sv
// -----------------------------------------------------------------------------
// tb_dot_product_seq
//   Self-checking bench for dot_product_seq with a behavioural mac_unit and a
//   reference model that sums products of the queued operand pairs.
// -----------------------------------------------------------------------------
module tb_dot_product_seq;

    localparam int DW = 8;
    localparam int AW = 16;
    localparam int LW = 8;
    localparam longint unsigned ACC_MOD = 64'd1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [LW-1:0] len = '0;
    logic          busy;
    logic          op_valid = 1'b0;
    logic          op_ready;
    logic [DW-1:0] op_a = '0;
    logic [DW-1:0] op_b = '0;
    logic [DW-1:0] mac_a;
    logic [DW-1:0] mac_b;
    logic [AW-1:0] mac_acc_in;
    logic [AW-1:0] mac_acc_out;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [AW-1:0] res_data;
    logic          res_ovf;

    int n_checks = 0;
    int n_fail   = 0;

    int unsigned qa[$];
    int unsigned qb[$];

    always #5 clk = ~clk;

    dot_product_seq #(.DATA_W(DW), .ACC_W(AW), .LEN_W(LW)) u_dut (
        .i_clk         (clk),
        .i_reset       (rst_n),
        .i_start       (start),
        .i_len         (len),
        .o_busy        (busy),
        .i_op_valid    (op_valid),
        .o_op_ready    (op_ready),
        .i_op_a        (op_a),
        .i_op_b        (op_b),
        .o_mac_a       (mac_a),
        .o_mac_b       (mac_b),
        .o_mac_acc_in  (mac_acc_in),
        .i_mac_acc_out (mac_acc_out),
        .o_res_valid   (res_valid),
        .i_res_ready   (res_ready),
        .o_res_data    (res_data),
        .o_res_ovf     (res_ovf)
    );

    // Behavioural mac_unit: registered acc_in + a*b, wrapping at AW bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mac_acc_out <= '0;
        else        mac_acc_out <= AW'(longint'(mac_acc_in) + longint'(mac_a) * longint'(mac_b));
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Map an exact unsigned sum onto the result the block should report.
    function automatic longint unsigned exp_data(input longint unsigned s);
`ifdef SAT_OVF_EN
        return (s >= ACC_MOD) ? ACC_MOD - 1 : s;
`else
        return s % ACC_MOD;
`endif
    endfunction

    function automatic bit exp_ovf(input longint unsigned s);
`ifdef SAT_OVF_EN
        return s >= ACC_MOD;
`else
        return 1'b0;
`endif
    endfunction

    // Entered and left at a negedge with all stimulus idle.
    task automatic run_vec(input int max_gap, input bit rand_gap, input int rdy_delay,
                           input bit pulse_start);
        int n;
        longint unsigned sum;
        int g;
        n   = qa.size();
        sum = 0;
        check_eq("idle_busy", busy, 1'b0);
        start = 1'b1;
        len   = LW'(n);
        @(negedge clk);
        start = 1'b0;
        len   = LW'($urandom);
        if (n != 0) begin
            check_eq("run_ready", op_ready, 1'b1);
            check_eq("run_busy", busy, 1'b1);
            for (int i = 0; i < n; i++) begin
                g = rand_gap ? int'($urandom_range(0, max_gap)) : max_gap;
                for (int k = 0; k < g; k++) begin
                    op_valid = 1'b0;
                    op_a     = DW'($urandom_range(1, 255));
                    op_b     = DW'($urandom_range(1, 255));
                    #1;
                    check_eq("gap_mac_a", mac_a, 0);
                    check_eq("gap_mac_b", mac_b, 0);
                    @(negedge clk);
                end
                op_valid = 1'b1;
                op_a     = DW'(qa[i]);
                op_b     = DW'(qb[i]);
                #1;
                check_eq("beat_ready", op_ready, 1'b1);
                check_eq("beat_mac_a", mac_a, qa[i]);
                check_eq("beat_mac_b", mac_b, qb[i]);
                check_eq("beat_acc_in", mac_acc_in, (i == 0) ? 0 : exp_data(sum));
                sum += longint'(qa[i]) * longint'(qb[i]);
                @(negedge clk);
                op_valid = 1'b0;
            end
            check_eq("drain_valid", res_valid, 1'b0);
            check_eq("drain_ready", op_ready, 1'b0);
            check_eq("drain_busy", busy, 1'b1);
            @(negedge clk);
        end
        check_eq("res_valid", res_valid, 1'b1);
        check_eq("res_data", res_data, exp_data(sum));
        check_eq("res_ovf", res_ovf, exp_ovf(sum));
        check_eq("hold_ready", op_ready, 1'b0);
        for (int k = 0; k < rdy_delay; k++) begin
            start    = pulse_start;
            op_valid = pulse_start;
            @(negedge clk);
            check_eq("stall_valid", res_valid, 1'b1);
            check_eq("stall_data", res_data, exp_data(sum));
            check_eq("stall_ovf", res_ovf, exp_ovf(sum));
            check_eq("stall_ready", op_ready, 1'b0);
        end
        start     = 1'b0;
        op_valid  = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check_eq("post_busy", busy, 1'b0);
        check_eq("post_valid", res_valid, 1'b0);
        @(negedge clk);
        check_eq("still_idle", busy, 1'b0);
    endtask

    initial begin
        #1;
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_op_ready", op_ready, 1'b0);
        check_eq("rst_res_valid", res_valid, 1'b0);
        check_eq("rst_res_data", res_data, 0);
        check_eq("rst_res_ovf", res_ovf, 1'b0);
        check_eq("rst_acc_in", mac_acc_in, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Back-to-back beats: 3*4 + 2*5 = 22.
        qa = '{3, 2}; qb = '{4, 5};
        run_vec(0, 1'b0, 0, 1'b0);

        // Two idle cycles before every beat: 1 + 4 + 9 = 14.
        qa = '{1, 2, 3}; qb = '{1, 2, 3};
        run_vec(2, 1'b0, 0, 1'b0);

        // Empty vector.
        qa.delete(); qb.delete();
        run_vec(0, 1'b0, 0, 1'b0);

        // Consumer stalls five cycles while start and op_valid are pulsed.
        qa = '{5, 6}; qb = '{7, 8};
        run_vec(0, 1'b0, 5, 1'b1);

        // Largest operands: wraps to 64514 or saturates.
        qa = '{255, 255}; qb = '{255, 255};
        run_vec(0, 1'b0, 1, 1'b0);

        // Random vectors, gaps and consumer stalls.
        for (int t = 0; t < 30; t++) begin
            int n;
            int unsigned lim;
            qa.delete(); qb.delete();
            n   = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 6));
            lim = $urandom_range(0, 1) ? 15 : 255;
            for (int i = 0; i < n; i++) begin
                qa.push_back($urandom_range(0, lim));
                qb.push_back($urandom_range(0, lim));
            end
            run_vec(2, 1'b1, int'($urandom_range(0, 3)), 1'(($urandom_range(0, 1))));
        end

        // Leave a nonzero result behind, then reset in the middle of a vector.
        qa = '{3, 2}; qb = '{4, 5};
        run_vec(0, 1'b0, 0, 1'b0);
        start = 1'b1;
        len   = LW'(4);
        @(negedge clk);
        start    = 1'b0;
        op_valid = 1'b1;
        op_a     = 8'd9;
        op_b     = 8'd9;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_busy", busy, 1'b0);
        check_eq("mid_rst_op_ready", op_ready, 1'b0);
        check_eq("mid_rst_res_valid", res_valid, 1'b0);
        check_eq("mid_rst_res_data", res_data, 0);
        check_eq("mid_rst_res_ovf", res_ovf, 1'b0);
        check_eq("mid_rst_acc_in", mac_acc_in, 0);
        op_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("after_rst_valid", res_valid, 1'b0);
        qa = '{7}; qb = '{6};
        run_vec(0, 1'b0, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard time limit so the run can never hang.
    initial begin
        #500000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "time limit reached");
    end

endmodule
